// File: rtl/painterengine_gpu_displayfetch.sv
// Display frame-fetch request generator: walks the clipped frame line by line and issues
// one burst read request at a time to the framebuffer reader.
module painterengine_gpu_displayfetch #(
  parameter int unsigned PIXEL_BYTES = 4,
  parameter int unsigned MAX_BURST   = 256
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_start,
  input  logic [31:0] i_wire_base_address,
  input  logic [15:0] i_wire_image_width,
  input  logic [15:0] i_wire_clip_width,
  input  logic [15:0] i_wire_clip_height,
  output logic        o_wire_req_valid,
  input  logic        i_wire_req_ready,
  output logic [31:0] o_wire_req_address,
  output logic [15:0] o_wire_req_length,
  output logic        o_wire_req_line_last,
  input  logic        i_wire_resp_done,
  output logic        o_wire_busy,
  output logic        o_wire_done
);

  localparam int unsigned Shift    = $clog2(PIXEL_BYTES);
  localparam logic [15:0] MaxBurst = 16'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q;
  logic [31:0] line_addr_q;
  logic [15:0] stride_q;
  logic [15:0] clip_w_q;
  logic [15:0] clip_h_q;
  logic [15:0] x_q;
  logic [15:0] y_q;

  logic        req_valid_q;
  logic [31:0] req_address_q;
  logic [15:0] req_length_q;
  logic        req_line_last_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] next_x;
  logic [31:0] next_line_addr;
  logic        more_lines;

  function automatic logic [15:0] burst_len(input logic [15:0] w, input logic [15:0] x);
    logic [15:0] rem;
    rem = w - x;
    return (rem > MaxBurst) ? MaxBurst : rem;
  endfunction

  function automatic logic ends_line(input logic [15:0] w, input logic [15:0] x);
    return (w - x) <= MaxBurst;
  endfunction

  function automatic logic [31:0] pixel_offset(input logic [15:0] x);
    return 32'(x) << Shift;
  endfunction

  always_comb begin
    next_x         = x_q + req_length_q;
    next_line_addr = line_addr_q + (32'(stride_q) << Shift);
    more_lines     = ({1'b0, y_q} + 17'd1) < {1'b0, clip_h_q};
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state_q         <= StIdle;
      line_addr_q     <= '0;
      stride_q        <= '0;
      clip_w_q        <= '0;
      clip_h_q        <= '0;
      x_q             <= '0;
      y_q             <= '0;
      req_valid_q     <= 1'b0;
      req_address_q   <= '0;
      req_length_q    <= '0;
      req_line_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_wire_start) begin
            line_addr_q <= i_wire_base_address;
            stride_q    <= i_wire_image_width;
            clip_w_q    <= i_wire_clip_width;
            clip_h_q    <= i_wire_clip_height;
            x_q         <= '0;
            y_q         <= '0;
            busy_q      <= 1'b1;
            if (i_wire_clip_width == '0 || i_wire_clip_height == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q         <= StReq;
              req_valid_q     <= 1'b1;
              req_address_q   <= i_wire_base_address;
              req_length_q    <= burst_len(i_wire_clip_width, 16'd0);
              req_line_last_q <= ends_line(i_wire_clip_width, 16'd0);
            end
          end
        end
        StReq: begin
          if (i_wire_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (i_wire_resp_done) begin
            if (!req_line_last_q) begin
              x_q             <= next_x;
              req_valid_q     <= 1'b1;
              req_address_q   <= line_addr_q + pixel_offset(next_x);
              req_length_q    <= burst_len(clip_w_q, next_x);
              req_line_last_q <= ends_line(clip_w_q, next_x);
              state_q         <= StReq;
            end else if (more_lines) begin
              x_q             <= '0;
              y_q             <= y_q + 16'd1;
              line_addr_q     <= next_line_addr;
              req_valid_q     <= 1'b1;
              req_address_q   <= next_line_addr;
              req_length_q    <= burst_len(clip_w_q, 16'd0);
              req_line_last_q <= ends_line(clip_w_q, 16'd0);
              state_q         <= StReq;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_wire_req_valid     = req_valid_q;
  assign o_wire_req_address   = req_address_q;
  assign o_wire_req_length    = req_length_q;
  assign o_wire_req_line_last = req_line_last_q;
  assign o_wire_busy          = busy_q;
  assign o_wire_done          = done_q;

endmodule

// File: tb/tb_painterengine_gpu_displayfetch.sv
// Scoreboard bench for the display frame-fetch generator: a frame-level model queues the
// expected requests and done pulse, a negedge monitor pops and compares.
module tb_painterengine_gpu_displayfetch;

  localparam int unsigned PB = 4;
  localparam int unsigned MB = 256;

  typedef struct {
    logic        is_done;
    logic [31:0] addr;
    logic [15:0] len;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_drv = 1'b0, start_glitch = 1'b0;
  logic        rsp_done = 1'b0, rsp_glitch = 1'b0;
  logic        start_w, resp_w;
  logic [31:0] base_in = '0;
  logic [15:0] width_in = '0, cw_in = '0, ch_in = '0;
  logic        ready = 1'b1;
  logic        valid, last, busy, done;
  logic [31:0] addr;
  logic [15:0] len;

  logic        ready_force = 1'b1, rand_ready = 1'b0, chaos = 1'b0;
  int          n_checks = 0, n_fail = 0;
  int          neg_cnt = 0, hs_count = 0, done_seen = 0, done_neg = 0;
  int          start_neg = 0, done_target = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic        prev_stall = 1'b0;
  logic [31:0] p_addr;
  logic [15:0] p_len;
  logic        p_last;

  assign start_w = start_drv | start_glitch;
  assign resp_w  = rsp_done | rsp_glitch;

  always #5 clk = ~clk;

  painterengine_gpu_displayfetch #(
    .PIXEL_BYTES(PB),
    .MAX_BURST  (MB)
  ) dut (
    .i_wire_clock        (clk),
    .i_wire_reset        (rst),
    .i_wire_start        (start_w),
    .i_wire_base_address (base_in),
    .i_wire_image_width  (width_in),
    .i_wire_clip_width   (cw_in),
    .i_wire_clip_height  (ch_in),
    .o_wire_req_valid    (valid),
    .i_wire_req_ready    (ready),
    .o_wire_req_address  (addr),
    .o_wire_req_length   (len),
    .o_wire_req_line_last(last),
    .i_wire_resp_done    (resp_w),
    .o_wire_busy         (busy),
    .o_wire_done         (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: every visible line split into bursts of at most MB pixels.
  task automatic push_model(input logic [31:0] base, input logic [15:0] stride,
                            input logic [15:0] w, input logic [15:0] h);
    exp_t e;
    int   x, l;
    logic [31:0] la;
    for (int y = 0; y < int'(h); y++) begin
      la = base + 32'(y) * 32'(stride) * 32'(PB);
      x  = 0;
      while (x < int'(w)) begin
        l = (int'(w) - x > int'(MB)) ? int'(MB) : int'(w) - x;
        e.is_done = 1'b0;
        e.addr    = la + 32'(x * int'(PB));
        e.len     = 16'(l);
        e.last    = (x + l == int'(w));
        sb.push_back(e);
        x += l;
      end
    end
    e.is_done = 1'b1;
    e.addr    = '0;
    e.len     = '0;
    e.last    = 1'b0;
    sb.push_back(e);
  endtask

  task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                             input logic [15:0] w, input logic [15:0] h);
    @(posedge clk);
    #1;
    base_in     = base;
    width_in    = stride;
    cw_in       = w;
    ch_in       = h;
    done_target = done_seen + 1;
    push_model(base, stride, w, h);
    start_drv = 1'b1;
    @(posedge clk);
    start_neg = neg_cnt;
    #1 start_drv = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_seen < done_target && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(done_seen >= done_target), 64'd1);
    @(negedge clk);
    #1;
    check({name, "_idle_after"}, {busy, done, valid}, 3'b000);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic run_frame(input string name, input logic [31:0] base,
                           input logic [15:0] stride, input logic [15:0] w,
                           input logic [15:0] h);
    start_frame(base, stride, w, h);
    wait_done(name);
  endtask

  always @(posedge clk) begin
    #1;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Spurious start/resp_done pulses only where they must be ignored, plus mid-frame input churn.
  always @(posedge clk) begin
    #1;
    if (chaos) begin
      start_glitch = busy && ($urandom_range(0, 2) == 0);
      rsp_glitch   = valid && ($urandom_range(0, 2) == 0);
      if (busy) begin
        base_in  = $urandom;
        width_in = 16'($urandom);
        cw_in    = 16'($urandom);
        ch_in    = 16'($urandom);
      end
    end else begin
      start_glitch = 1'b0;
      rsp_glitch   = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid && ready) begin
        repeat (3) @(posedge clk);
        #1 rsp_done = 1'b1;
        @(posedge clk);
        #1 rsp_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    neg_cnt++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {valid, addr, len, last}, {1'b1, p_addr, p_len, p_last});
      if (valid && ready) begin
        hs_count++;
        if (sb.size() == 0 || sb[0].is_done) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: actual addr=%h len=%0d required none", addr, len);
        end else begin
          mon_e = sb.pop_front();
          check("req", {addr, len, last}, {mon_e.addr, mon_e.len, mon_e.last});
        end
      end
      if (done) begin
        done_seen++;
        done_neg = neg_cnt;
        if (sb.size() == 0 || !sb[0].is_done) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: actual done=1 required 0 (queue=%0d)", sb.size());
        end else begin
          mon_e = sb.pop_front();
          check("done_busy", 64'(busy), 64'd1);
        end
      end
      prev_stall = valid && !ready;
      p_addr     = addr;
      p_len      = len;
      p_last     = last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0, n, d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_last", 64'(last), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_len", 64'(len), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame("multiline", 32'h1000_0000, 16'd1280, 16'd600, 16'd2);
    run_frame("exact512", 32'h2000_0000, 16'd512, 16'd512, 16'd1);

    start_frame(32'h0, 16'd100, 16'd0, 16'd720);
    wait_done("zero_w");
    check("zero_w_latency", 64'(done_neg), 64'(start_neg + 1));
    start_frame(32'h0, 16'd1280, 16'd1280, 16'd0);
    wait_done("zero_h");
    check("zero_h_latency", 64'(done_neg), 64'(start_neg + 1));

    ready_force = 1'b0;
    fork
      run_frame("backpressure", 32'h0000_4000, 16'd640, 16'd600, 16'd1);
      begin
        n = 0;
        while (!valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        ready_force = 1'b1;
      end
    join

    chaos = 1'b1;
    run_frame("chaos", 32'h0123_4560, 16'd700, 16'd600, 16'd3);
    chaos = 1'b0;

    run_frame("wrap", 32'hFFFF_FC00, 16'd256, 16'd256, 16'd2);

    // Reset while the second request is stalled on valid.
    h0 = hs_count;
    start_frame(32'h1000_0000, 16'd1280, 16'd600, 16'd2);
    n = 0;
    while (hs_count < h0 + 1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    ready_force = 1'b0;
    n = 0;
    @(negedge clk);
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_req2", {64'(hs_count), 63'd0, valid}, {64'(h0 + 1), 64'd1});
    #1 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {valid, busy, done, last, addr, len}, 52'd0);
    sb.delete();
    d0 = done_seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ready_force = 1'b1;
    repeat (12) @(posedge clk);
    check("rst_mid_no_done", 64'(done_seen), 64'(d0));
    run_frame("after_reset", 32'h1000_0000, 16'd1280, 16'd600, 16'd2);

    rand_ready = 1'b1;
    chaos      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] w, h;
      w = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 700));
      h = 16'($urandom_range(0, 3));
      run_frame("random", $urandom, 16'($urandom_range(0, 2000)), w, h);
    end
    rand_ready = 1'b0;
    chaos      = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
